// File: rtl/rtype_pkg.sv
// Shared types, opcode constants and the R-type funct decoder for the multi-cycle core.
package rtype_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK
  } state_e;

  // R-type instruction word layout, MSB first.
  typedef struct packed {
    logic [6:0]           funct7;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rs1;
    logic [2:0]           funct3;
    logic [REG_IDX_W-1:0] rd;
    logic [6:0]           opcode;
  } rtype_instr_t;

  typedef struct packed {
    alu_op_e op;
    logic    legal;
  } dec_t;

  function automatic dec_t decode_rtype(input logic [2:0] funct3, input logic [6:0] funct7);
    dec_t d;
    logic alt;
    alt     = (funct7 == F7_ALT);
    d.op    = ALU_ADD;
    d.legal = (funct7 == F7_BASE) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
    case (funct3)
      3'b000:  d.op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  d.op = ALU_SLL;
      3'b010:  d.op = ALU_SLT;
      3'b011:  d.op = ALU_SLTU;
      3'b100:  d.op = ALU_XOR;
      3'b101:  d.op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  d.op = ALU_OR;
      default: d.op = ALU_AND;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rtype_multicycle_core_if.sv
// Instruction-fetch handshake and retire reporting between the core and its environment.
interface rtype_multicycle_core_if
  import rtype_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_instr;
  logic               retire_valid;
  logic [XLEN-1:0]    retire_pc;
  logic               retire_illegal;

  modport master (
    output imem_req, imem_addr, retire_valid, retire_pc, retire_illegal,
    input  imem_valid, imem_instr
  );

  modport slave (
    input  imem_req, imem_addr, retire_valid, retire_pc, retire_illegal,
    output imem_valid, imem_instr
  );

endinterface

// File: rtl/rtype_alu.sv
// Combinational RV32 R-type ALU; shifts use the low log2(XLEN) bits of b.
module rtype_alu
  import rtype_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y_c
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    y_c = '0;
    unique case (op)
      ALU_ADD:  y_c = a + b;
      ALU_SUB:  y_c = a - b;
      ALU_SLL:  y_c = a << shamt;
      ALU_SRL:  y_c = a >> shamt;
      ALU_SRA:  y_c = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  y_c = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y_c = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  y_c = a ^ b;
      ALU_OR:   y_c = a | b;
      ALU_AND:  y_c = a & b;
      default:  y_c = '0;
    endcase
  end

endmodule

// File: rtl/rtype_multicycle_core.sv
// Multi-cycle R-type core: FETCH/DECODE/EXECUTE/WRITEBACK FSM, register file,
// debug RF port and retire reporting.
module rtype_multicycle_core
  import rtype_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  rtype_multicycle_core_if.master bus,
  input  logic                   dbg_we,
  input  logic [REG_IDX_W-1:0]   dbg_addr,
  input  logic [XLEN-1:0]        dbg_wdata,
  output logic [XLEN-1:0]        dbg_rdata,
  output logic                   busy
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0) begin : g_bad_xlen
    $error("XLEN must be a power of two and at least 8");
  end
  if (NREGS < 2 || NREGS > 32 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("NREGS must be a power of two between 2 and 32");
  end

  state_e          state, state_d;
  logic [XLEN-1:0] pc, a, b, r, alu_y;
  logic [INSTR_W-1:0] ir;
  logic            legal_q;
  alu_op_e         op_q;
  logic            imem_req_q, retire_valid_q, retire_illegal_q;
  logic [XLEN-1:0] retire_pc_q;
  logic            ir_ld, opnd_ld, res_ld, wb_en, dbg_en;
  rtype_instr_t    ins;
  dec_t            dec;
  logic            legal_c;

  logic [XLEN-1:0] rf [NREGS];

  function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  // x0 and indices beyond the implemented file read as zero.
  function automatic logic [XLEN-1:0] rf_rd(input logic [REG_IDX_W-1:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != '0 && idx_ok(idx)) v = rf[idx[RIDX_W-1:0]];
    return v;
  endfunction

  assign ins       = rtype_instr_t'(ir);
  assign dec       = decode_rtype(ins.funct3, ins.funct7);
  assign legal_c   = dec.legal && (ins.opcode == OPC_RTYPE) &&
                     idx_ok(ins.rs1) && idx_ok(ins.rs2) && idx_ok(ins.rd);
  assign dbg_rdata = rf_rd(dbg_addr);

  rtype_alu #(.XLEN(XLEN)) u_alu (
    .a   (a),
    .b   (b),
    .op  (op_q),
    .y_c (alu_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state plus per-state datapath load strobes.
  always_comb begin
    state_d = state;
    ir_ld   = 1'b0;
    opnd_ld = 1'b0;
    res_ld  = 1'b0;
    wb_en   = 1'b0;
    dbg_en  = 1'b0;
    unique case (state)
      IDLE: begin
        dbg_en = dbg_we;
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_valid) begin
          ir_ld   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opnd_ld = 1'b1;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        res_ld  = 1'b1;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc               <= PC_RESET;
      ir               <= '0;
      a                <= '0;
      b                <= '0;
      r                <= '0;
      legal_q          <= 1'b0;
      op_q             <= ALU_ADD;
      imem_req_q       <= 1'b0;
      busy             <= 1'b0;
      retire_valid_q   <= 1'b0;
      retire_illegal_q <= 1'b0;
      retire_pc_q      <= '0;
    end else begin
      if (ir_ld) ir <= bus.imem_instr;
      if (opnd_ld) begin
        a       <= rf_rd(ins.rs1);
        b       <= rf_rd(ins.rs2);
        legal_q <= legal_c;
        op_q    <= dec.op;
      end
      if (res_ld) r <= alu_y;
      if (wb_en)  pc <= pc + XLEN'(4);
      // Outputs are registered from the next state so they align with it.
      imem_req_q       <= (state_d == FETCH);
      busy             <= (state_d != IDLE);
      retire_valid_q   <= (state_d == WRITEBACK);
      retire_illegal_q <= (state_d == WRITEBACK) && !legal_q;
      if (state_d == WRITEBACK) retire_pc_q <= pc;
    end
  end

  // Architectural writeback and debug writes share one write port; they never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[RIDX_W'(i)] <= '0;
    end else if (wb_en) begin
      if (legal_q && ins.rd != '0) rf[ins.rd[RIDX_W-1:0]] <= r;
    end else if (dbg_en && dbg_addr != '0 && idx_ok(dbg_addr)) begin
      rf[dbg_addr[RIDX_W-1:0]] <= dbg_wdata;
    end
  end

  assign bus.imem_req       = imem_req_q;
  assign bus.imem_addr      = pc;
  assign bus.retire_valid   = retire_valid_q;
  assign bus.retire_pc      = retire_pc_q;
  assign bus.retire_illegal = retire_illegal_q;

endmodule

// File: tb/tb_rtype_multicycle_core.sv
// Scoreboard bench: two cores (RV32I at PC 0, RV32E at PC 0xFFFFFFFC) driven by directed R-type vectors.
module tb_rtype_multicycle_core;

  typedef struct {
    logic [31:0] pc;
    logic        ill;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, run_a, run_b, dbg_we_a, dbg_we_b, imem_valid, sel;
  logic [31:0] imem_instr, dbg_wdata, dbg_rdata_a, dbg_rdata_b;
  logic [4:0]  dbg_addr;
  logic        busy_a, busy_b;
  logic [31:0] addr_s, rdata_s;
  logic        req_s, busy_s;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;

  rtype_multicycle_core_if #(.XLEN(32)) ifa ();
  rtype_multicycle_core_if #(.XLEN(32)) ifb ();

  assign ifa.imem_valid = imem_valid;
  assign ifa.imem_instr = imem_instr;
  assign ifb.imem_valid = imem_valid;
  assign ifb.imem_instr = imem_instr;

  rtype_multicycle_core #(.XLEN(32), .NREGS(32), .PC_RESET(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .bus(ifa),
    .dbg_we(dbg_we_a), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata_a), .busy(busy_a)
  );

  rtype_multicycle_core #(.XLEN(32), .NREGS(16), .PC_RESET(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .bus(ifb),
    .dbg_we(dbg_we_b), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata_b), .busy(busy_b)
  );

  assign addr_s  = sel ? ifb.imem_addr : ifa.imem_addr;
  assign req_s   = sel ? ifb.imem_req  : ifa.imem_req;
  assign busy_s  = sel ? busy_b        : busy_a;
  assign rdata_s = sel ? dbg_rdata_b   : dbg_rdata_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Retire monitors pop the scoreboard whenever a core reports a retirement.
  always @(negedge clk) begin
    if (ifa.retire_valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL a_spurious_retire: got retire pc 0x%08h, expected no retire", ifa.retire_pc);
      end else begin
        ea = qa.pop_front();
        chk("a_retire_pc", ifa.retire_pc, ea.pc);
        chk("a_retire_illegal", 32'(ifa.retire_illegal), 32'(ea.ill));
        chk("a_retire_cycle", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.retire_valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL b_spurious_retire: got retire pc 0x%08h, expected no retire", ifb.retire_pc);
      end else begin
        eb = qb.pop_front();
        chk("b_retire_pc", ifb.retire_pc, eb.pc);
        chk("b_retire_illegal", 32'(ifb.retire_illegal), 32'(eb.ill));
        chk("b_retire_cycle", cyc, eb.cyc);
      end
    end
  end

  task automatic dbg_write(input logic s, input logic [4:0] idx, input logic [31:0] d);
    dbg_addr = idx; dbg_wdata = d;
    if (s) dbg_we_b = 1'b1; else dbg_we_a = 1'b1;
    @(negedge clk);
    dbg_we_a = 1'b0; dbg_we_b = 1'b0;
  endtask

  task automatic dbg_check(input logic s, input string name, input logic [4:0] idx, input logic [31:0] exp);
    sel = s; dbg_addr = idx;
    #1;
    chk(name, rdata_s, exp);
  endtask

  // Runs one instruction from IDLE; run is dropped in FETCH so the core parks after retiring.
  task automatic exec_one(input logic s, input logic [31:0] instr, input int stall,
                          input logic [31:0] pc_e, input logic ill);
    exp_t        e;
    int unsigned c0;
    sel = s;
    c0  = cyc;
    if (s) run_b = 1'b1; else run_a = 1'b1;
    @(negedge clk);
    run_a = 1'b0; run_b = 1'b0;
    chk("fetch_req", 32'(req_s), 32'd1);
    chk("fetch_addr", addr_s, pc_e);
    for (int k = 0; k < stall; k++) begin
      dbg_addr = 5'd10; dbg_wdata = 32'h0000_0099;
      if (s) dbg_we_b = 1'b1; else dbg_we_a = 1'b1;
      @(negedge clk);
      chk("stall_req", 32'(req_s), 32'd1);
      chk("stall_addr", addr_s, pc_e);
    end
    dbg_we_a = 1'b0; dbg_we_b = 1'b0;
    imem_valid = 1'b1; imem_instr = instr;
    e.pc = pc_e; e.ill = ill; e.cyc = c0 + 4 + int'(stall);
    if (s) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    imem_valid = 1'b0; imem_instr = '0;
    for (int k = 0; k < 10 && busy_s; k++) @(negedge clk);
    chk("back_to_idle", 32'(busy_s), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; run_a = 1'b0; run_b = 1'b0; dbg_we_a = 1'b0; dbg_we_b = 1'b0;
    imem_valid = 1'b0; imem_instr = '0; dbg_addr = '0; dbg_wdata = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_imem_req", 32'(ifa.imem_req), 32'd0);
    chk("rst_retire_valid", 32'(ifa.retire_valid), 32'd0);
    chk("rst_retire_illegal", 32'(ifa.retire_illegal), 32'd0);
    chk("rst_retire_pc", ifa.retire_pc, 32'd0);
    chk("rst_pc_a", ifa.imem_addr, 32'd0);
    chk("rst_pc_b", ifb.imem_addr, 32'hFFFF_FFFC);
    rst = 1'b1;
    @(negedge clk);

    dbg_write(0, 5'd1, 32'd5);
    dbg_write(0, 5'd2, 32'd3);
    dbg_write(0, 5'd0, 32'h77);
    dbg_check(0, "dbg_x0", 5'd0, 32'd0);
    dbg_check(0, "dbg_x1", 5'd1, 32'd5);
    exec_one(0, 32'h0020_81B3, 0, 32'h00, 1'b0);
    dbg_check(0, "add_x3", 5'd3, 32'd8);

    dbg_write(0, 5'd1, 32'hFFFF_FFF0);
    dbg_write(0, 5'd2, 32'd4);
    exec_one(0, 32'h4020_D1B3, 0, 32'h04, 1'b0);
    dbg_check(0, "sra_x3", 5'd3, 32'hFFFF_FFFF);
    exec_one(0, 32'h0020_D1B3, 0, 32'h08, 1'b0);
    dbg_check(0, "srl_x3", 5'd3, 32'h0FFF_FFFF);

    dbg_write(0, 5'd1, 32'hFFFF_FFFF);
    dbg_write(0, 5'd2, 32'd1);
    exec_one(0, 32'h0020_A1B3, 0, 32'h0C, 1'b0);
    dbg_check(0, "slt_x3", 5'd3, 32'd1);
    exec_one(0, 32'h4020_F1B3, 0, 32'h10, 1'b1);
    dbg_check(0, "ill_f7_x3", 5'd3, 32'd1);
    exec_one(0, 32'h0020_8193, 0, 32'h14, 1'b1);
    dbg_check(0, "ill_opc_x3", 5'd3, 32'd1);
    exec_one(0, 32'h0020_B1B3, 0, 32'h18, 1'b0);
    dbg_check(0, "sltu_x3", 5'd3, 32'd0);
    exec_one(0, 32'h4020_8033, 0, 32'h1C, 1'b0);
    dbg_check(0, "sub_x0", 5'd0, 32'd0);
    exec_one(0, 32'h4020_8233, 0, 32'h20, 1'b0);
    dbg_check(0, "sub_x4", 5'd4, 32'hFFFF_FFFE);
    exec_one(0, 32'h0020_F2B3, 0, 32'h24, 1'b0);
    dbg_check(0, "and_x5", 5'd5, 32'd1);
    exec_one(0, 32'h0020_9333, 0, 32'h28, 1'b0);
    dbg_check(0, "sll_x6", 5'd6, 32'hFFFF_FFFE);
    exec_one(0, 32'h0020_C5B3, 0, 32'h2C, 1'b0);
    dbg_check(0, "xor_x11", 5'd11, 32'hFFFF_FFFE);
    exec_one(0, 32'h0020_E4B3, 3, 32'h30, 1'b0);
    dbg_check(0, "or_x9_stalled", 5'd9, 32'hFFFF_FFFF);
    dbg_check(0, "dbg_busy_ignored_x10", 5'd10, 32'd0);

    // Reset lands while ADD x8 is in EXECUTE: nothing may retire or be written.
    dbg_write(0, 5'd7, 32'h55);
    sel = 1'b0; run_a = 1'b1;
    @(negedge clk);
    run_a = 1'b0; imem_valid = 1'b1; imem_instr = 32'h0020_8433;
    @(negedge clk);
    imem_valid = 1'b0; imem_instr = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_req", 32'(ifa.imem_req), 32'd0);
    chk("midrst_pc", ifa.imem_addr, 32'd0);
    dbg_check(0, "midrst_x7", 5'd7, 32'd0);
    dbg_check(0, "midrst_x1", 5'd1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_stays_idle", 32'(busy_a), 32'd0);
    dbg_check(0, "midrst_x8", 5'd8, 32'd0);

    chk("b_pc_reset", ifb.imem_addr, 32'hFFFF_FFFC);
    dbg_write(1, 5'd1, 32'd5);
    dbg_write(1, 5'd2, 32'd3);
    dbg_write(1, 5'd17, 32'h1234);
    dbg_check(1, "b_x17", 5'd17, 32'd0);
    dbg_check(1, "b_x1", 5'd1, 32'd5);
    exec_one(1, 32'h0020_88B3, 0, 32'hFFFF_FFFC, 1'b1);
    chk("b_pc_wrap", ifb.imem_addr, 32'd0);
    exec_one(1, 32'h0020_81B3, 0, 32'h0, 1'b0);
    dbg_check(1, "b_add_x3", 5'd3, 32'd8);
    exec_one(1, 32'h0028_01B3, 0, 32'h4, 1'b1);
    dbg_check(1, "b_rs1_oor_x3", 5'd3, 32'd8);

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
